uart_tx: RTL and testbench

Asynchronous serial transmitter, the counterpart of the team's 8N1 serial receiver. It accepts one byte per ready/start handshake from the system side. It serialises the byte as 1 start bit, 8 data bits (LSB first) and 1 stop bit on a registered tx line. It sits between the echo/application logic and the FTDI/USB-serial TX pin.

---
 rtl/uart_tx_if.sv | 20 ++
 rtl/uart_tx.sv | 83 ++++++++
 tb/tb_uart_tx.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_if
// Description : Byte handshake between the application side and uart_tx.
//               master : application (drives start/data, observes ready)
//               slave  : transmitter (observes start/data, drives ready)
//   start  1  request to send; only acted on while ready=1
//   data   8  byte to send; sampled in the accept cycle only
//   ready  1  transmitter idle and able to accept a byte
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_if;
    logic       start;
    logic [7:0] data;
    logic       ready;

    modport master (output start, output data, input  ready);
    modport slave  (input  start, input  data, output ready);
endinterface
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : 8N1 asynchronous serial transmitter. One byte is accepted per
//               start/ready handshake and sent as start bit, d0..d7 (LSB
//               first) and one stop bit, each held BAUD_DIV clock cycles.
//   clk    in   1  system clock
//   rstn   in   1  synchronous active-low reset
//   bus    slave   start/data/ready handshake (uart_tx_if)
//   tx     out  1  serial line, idle high, driven straight from a flop
// Parameters  : BAUD_DIV - clock cycles per serial bit (2..65535)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int BAUD_DIV = 1250
) (
    input  wire logic clk,
    input  wire logic rstn,
    uart_tx_if.slave  bus,
    output logic      tx
);

    localparam int              c_CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_BAUD_MAX = c_CNT_W'(BAUD_DIV - 1);
    localparam logic [3:0]      c_LAST_BIT = 4'd10;

    localparam logic [1:0] c_IDLE = 2'b00;
    localparam logic [1:0] c_SEND = 2'b01;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_baud;
    logic [3:0]         r_bit;
    // Bit 0 of the frame register is the line itself; everything to the left
    // is still to be sent. Shifting in ones leaves the line idle-high once the
    // stop bit has gone out.
    logic [9:0]         r_shift;
    logic               w_tick;

    assign w_tick    = (r_baud == c_BAUD_MAX);
    // Any state other than SEND (including unused encodings) behaves as idle.
    assign bus.ready = (r_state != c_SEND);
    assign tx        = r_shift[0];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= c_IDLE;
            r_baud  <= '0;
            r_bit   <= 4'd0;
            r_shift <= '1;
        end else begin
            case (r_state)
                c_SEND: begin
                    if (w_tick) begin
                        r_baud  <= '0;
                        r_shift <= {1'b1, r_shift[9:1]};
                        if (r_bit != c_LAST_BIT) begin
                            r_bit <= r_bit + 4'd1;
                        end
                        // This tick completes the stop bit.
                        if (r_bit == c_LAST_BIT - 4'd1) begin
                            r_state <= c_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + c_CNT_W'(1);
                    end
                end
                default: begin
                    r_baud <= '0;
                    if (bus.start) begin
                        r_shift <= {1'b1, bus.data, 1'b0};
                        r_bit   <= 4'd0;
                        r_state <= c_SEND;
                    end else begin
                        r_shift <= '1;
                        r_state <= c_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Directed self-checking bench for uart_tx. One instance runs at
//               BAUD_DIV=4 for frame-level checks, a second at the default
//               BAUD_DIV=1250 for the bit-period check.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    logic clk;
    logic rstn;
    logic tx_a;
    logic tx_b;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    uart_tx_if if_a ();
    uart_tx_if if_b ();

    uart_tx #(.BAUD_DIV(4)) dut_a (
        .clk  (clk),
        .rstn (rstn),
        .bus  (if_a.slave),
        .tx   (tx_a)
    );

    uart_tx #(.BAUD_DIV(1250)) dut_b (
        .clk  (clk),
        .rstn (rstn),
        .bus  (if_b.slave),
        .tx   (tx_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic line_of(input bit sel);
        line_of = sel ? tx_b : tx_a;
    endfunction

    // Present a byte on instance A for one cycle; returns at the first sample
    // after the accept edge (cycle T+1).
    task automatic accept_a(input logic [7:0] b);
        if_a.data  = b;
        if_a.start = 1'b1;
        tick();
        if_a.start = 1'b0;
    endtask

    // Reference receiver: waits (bounded) for a falling edge, samples every
    // bit at its centre and checks start/stop levels.
    task automatic rx_frame(input bit sel, input int baud, input bit drop,
                            output logic [7:0] d, output int fall);
        int n;
        n = 0;
        d = 8'hxx;
        fall = -1;
        while (line_of(sel) !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (line_of(sel) !== 1'b0) begin
            failures++;
            $display("FAIL rx_wait_start: line=%b after %0d cycles, required 0", line_of(sel), n);
            return;
        end
        fall = cyc;
        if (drop) begin
            if_a.start = 1'b0;
            if_b.start = 1'b0;
        end
        repeat (baud / 2) tick();
        checks++;
        if (line_of(sel) !== 1'b0) begin
            failures++;
            $display("FAIL rx_start_mid: line=%b required 0", line_of(sel));
        end
        for (int k = 0; k < 8; k++) begin
            repeat (baud) tick();
            d[k] = line_of(sel);
        end
        repeat (baud) tick();
        checks++;
        if (line_of(sel) !== 1'b1) begin
            failures++;
            $display("FAIL rx_stop_bit: line=%b required 1", line_of(sel));
        end
    endtask

    // Checks instance A cycle by cycle from T+1 through T+41. Optional start
    // pulses with data=FF are injected at sample indices pa/pb (sample j is
    // cycle T+1+j).
    task automatic check_frame_a(input logic [7:0] b, input int pa, input int pb);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int j = 0; j < 40; j++) begin
            if (j == pa || j == pb) begin
                if_a.start = 1'b1;
                if_a.data  = 8'hFF;
            end else begin
                if_a.start = 1'b0;
            end
            checks++;
            if (tx_a !== fr[j / 4] || if_a.ready !== 1'b0) begin
                failures++;
                $display("FAIL frame_%h_cycle%0d: tx=%b ready=%b required tx=%b ready=0",
                         b, j + 1, tx_a, if_a.ready, fr[j / 4]);
            end
            tick();
        end
        if_a.start = 1'b0;
        checks++;
        if (tx_a !== 1'b1 || if_a.ready !== 1'b1) begin
            failures++;
            $display("FAIL frame_%h_end: tx=%b ready=%b required tx=1 ready=1", b, tx_a, if_a.ready);
        end
    endtask

    task automatic test_reset();
        rstn       = 1'b0;
        if_a.start = 1'b1;
        if_a.data  = 8'hA5;
        if_b.start = 1'b0;
        if_b.data  = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (tx_a !== 1'b1 || if_a.ready !== 1'b1) begin
                failures++;
                $display("FAIL reset_hold_%0d: tx=%b ready=%b required tx=1 ready=1", i, tx_a, if_a.ready);
            end
        end
        checks++;
        if (tx_b !== 1'b1 || if_b.ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_dut_b: tx=%b ready=%b required tx=1 ready=1", tx_b, if_b.ready);
        end
        rstn = 1'b1;
        tick();
        checks++;
        if (tx_a !== 1'b0 || if_a.ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_accept: tx=%b ready=%b required tx=0 ready=0", tx_a, if_a.ready);
        end
        if_a.start = 1'b0;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        checks++;
        if (tx_a !== 1'b1 || if_a.ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_abort: tx=%b ready=%b required tx=1 ready=1", tx_a, if_a.ready);
        end
    endtask

    task automatic test_single_byte();
        accept_a(8'hA5);
        check_frame_a(8'hA5, -1, -1);
    endtask

    task automatic test_ignored_start();
        accept_a(8'h3C);
        check_frame_a(8'h3C, 4, 19);
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (tx_a !== 1'b1 || if_a.ready !== 1'b1) begin
                failures++;
                $display("FAIL ignored_no_second_frame_%0d: tx=%b ready=%b required tx=1 ready=1",
                         i, tx_a, if_a.ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d1;
        logic [7:0] d2;
        int f1;
        int f2;
        int n;
        if_a.data  = 8'h00;
        if_a.start = 1'b1;
        tick();
        if_a.data = 8'hFF;
        rx_frame(1'b0, 4, 1'b0, d1, f1);
        rx_frame(1'b0, 4, 1'b1, d2, f2);
        if_a.start = 1'b0;
        checks++;
        if (d1 !== 8'h00) begin
            failures++;
            $display("FAIL b2b_first_byte: got %h required 00", d1);
        end
        checks++;
        if (d2 !== 8'hFF) begin
            failures++;
            $display("FAIL b2b_second_byte: got %h required ff", d2);
        end
        checks++;
        if (f2 - f1 !== 41) begin
            failures++;
            $display("FAIL b2b_spacing: got %0d cycles required 41", f2 - f1);
        end
        n = 0;
        while (if_a.ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset_midframe();
        accept_a(8'h55);
        repeat (12) tick();
        rstn = 1'b0;
        tick();
        checks++;
        if (tx_a !== 1'b1 || if_a.ready !== 1'b1) begin
            failures++;
            $display("FAIL midframe_reset: tx=%b ready=%b required tx=1 ready=1", tx_a, if_a.ready);
        end
        rstn = 1'b1;
        tick();
        checks++;
        if (tx_a !== 1'b1 || if_a.ready !== 1'b1) begin
            failures++;
            $display("FAIL midframe_after_release: tx=%b ready=%b required tx=1 ready=1", tx_a, if_a.ready);
        end
        accept_a(8'h81);
        check_frame_a(8'h81, -1, -1);
    endtask

    task automatic test_default_rate();
        logic [7:0] d;
        int f;
        int n;
        if_b.data  = 8'h41;
        if_b.start = 1'b1;
        tick();
        if_b.start = 1'b0;
        n = 0;
        while (tx_b === 1'b0 && n < 3000) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 1250) begin
            failures++;
            $display("FAIL rate_start_bit_len: got %0d cycles required 1250", n);
        end
        n = 0;
        while (tx_b === 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 1250) begin
            failures++;
            $display("FAIL rate_d0_len: got %0d cycles required 1250", n);
        end
        n = 0;
        while (if_b.ready !== 1'b1 && n < 20000) begin
            tick();
            n++;
        end
        if_b.data  = 8'h41;
        if_b.start = 1'b1;
        tick();
        rx_frame(1'b1, 1250, 1'b1, d, f);
        checks++;
        if (d !== 8'h41) begin
            failures++;
            $display("FAIL rate_rx_byte: got %h required 41", d);
        end
    endtask

    initial begin
        rstn       = 1'b0;
        if_a.start = 1'b0;
        if_a.data  = 8'h00;
        if_b.start = 1'b0;
        if_b.data  = 8'h00;
        test_reset();
        test_single_byte();
        test_ignored_start();
        test_back_to_back();
        test_reset_midframe();
        test_default_rate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
